adjacent_swap_sweeper: RTL
==========================

# adjacent_swap_sweeper

Tour-improvement controller that drives the adjacent-swap checker from the initiator side. It holds city coordinates and a tour order, and slides a 4-city window along the open path. For each window it presents the four points to the checker, restarts the checker, waits for its verdict, and swaps the two middle cities when the checker reports an improvement. It repeats passes until a pass makes no swap or a pass limit is reached.

## Interface
- N, 16: number of cities; must be >= 4. CW = $clog2(N).
- MAX_PASSES, 8: hard limit on sweep passes per start.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  write one city's coordinates (ignored while busy)
- load_idx  in  CW  city id to write
- load_x, load_y  in  8 each  coordinates
- start  in  1  begin sweep (ignored while busy)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- swaps  out  16  swaps applied in the last sweep
- passes  out  8  passes executed in the last sweep
- total_gain  out  32  sum of chk_difference over applied swaps
- rd_idx  in  CW  tour position to read
- rd_city  out  CW  tour[rd_idx], combinational
- chk_rst  out  1  checker restart, active-high
- chk_x1, chk_y1 … chk_x4, chk_y4  out  8 each  window points
- chk_res  in  1  1 = swapped order is shorter
- chk_complete  in  1  checker verdict valid
- chk_difference  in  32  old minus new path length

## Operation
- Storage: cx[N], cy[N] (8-bit), tour[N] (CW-bit).
  - On reset: tour[k] = k, coordinates = 0.
  - Tour is not reinitialised on start, so repeated starts keep refining.
- States:
  - IDLE: chk_rst = 1, busy = 0. Accepts load_valid. On start, clears swaps, passes and total_gain, sets i = 0 and pass_swaps = 0, and goes to SETUP.
  - SETUP: registers chk_x/y from the cities at tour[i..i+3] and holds chk_rst = 1. Goes to RUN.
  - RUN: chk_rst = 0. Outputs are held stable. Waits for chk_complete = 1, then goes to APPLY.
  - APPLY: if chk_res = 1, exchanges tour[i+1] and tour[i+2], increments swaps and pass_swaps, and adds chk_difference to total_gain. Drives chk_rst = 1. Then:
    - if i < N-4: i++, go to SETUP;
    - otherwise go to PASS_END.
  - PASS_END: increments passes. Then:
    - if pass_swaps == 0 or passes == MAX_PASSES (post-increment), go to DONE;
    - otherwise i = 0, pass_swaps = 0, go to SETUP.
  - DONE: done = 1 for one cycle, then IDLE.
- Window indexing:
  - Windows cover i = 0..N-4. The path is open, with no wrap-around.
  - A swap at i is visible to the window at i+1.
- Arithmetic:
  - total_gain wraps modulo 2^32.
  - chk_difference is used only when chk_res = 1, so it is positive.
  - swaps saturates at 16'hFFFF.

## Timing
- Reset values: busy 0, done 0, swaps 0, passes 0, total_gain 0, chk_rst 1, chk_x/y all 0.
- Per window: 1 SETUP cycle + checker latency + 1 APPLY cycle. With the team checker (8 cycles from chk_rst release to chk_complete) this is 10 cycles.
- A full sweep of P passes costs P·(N-3)·10 + P + 2 cycles after start.
- start and load_valid in the same IDLE cycle: the load is applied, and the sweep sees the new coordinates.
- start or load_valid while busy: ignored, no side effect.
- chk_complete seen outside RUN: ignored.
- rst mid-sweep:
  - Returns to IDLE next cycle.
  - Tour returns to identity and coordinates clear.
  - chk_rst = 1; no done pulse.
- rd_city is combinational from current tour, including mid-sweep updates.

## Structure
- Shared package sweep_pkg:
  - state enum (IDLE, SETUP, RUN, APPLY, PASS_END, DONE);
  - coordinate width 8;
  - checker result width 32.
- Sub-module swap_tour_regfile:
  - holds the tour array;
  - provides 4 combinational read ports for the window, 1 for rd_idx, and a single-cycle exchange port (two indices, enable).
- The checker is instantiated outside this block and connected at the chk_* ports, so the bench can substitute a model.

## Test plan
- Bench model: behavioural checker with Manhattan distance and an 8-cycle latency. One regression repeats the suite with the real checker.
- N=4, cities (0,0),(10,0),(20,0),(30,0), start:
  - checker window is (0,0),(10,0),(20,0),(30,0) -> chk_res 0;
  - done after 10 window cycles + 3 overhead, so done pulses 13 cycles after start;
  - passes=1, swaps=0, total_gain=0.
- N=4, cities 0..3 at (0,0),(20,0),(10,0),(30,0):
  - pass 1 swaps -> tour = 0,2,1,3, total_gain = 20;
  - pass 2 makes no swap -> passes=2, swaps=1.
- N=6 with the 4-city pattern above at tour positions 2..5 -> swap at i=2 only; rd_idx 3/4 read 4/3.
- MAX_PASSES=1, input needs ≥2 passes -> done after one pass, passes=1.
- Assert rst in cycle 5 of RUN -> next cycle busy=0, chk_rst=1, rd_city(k)=k, no done pulse.
- start pulsed while busy, and load_valid while busy -> no restart, no coordinate change; final results identical to an unperturbed run.

Source files
------------

// File: rtl/adjacent_swap_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// sweep_pkg: shared types for the adjacent-swap sweeper.
// Revision: 1.0
// ============================================================================
package sweep_pkg;

  localparam int COORD_W = 8;
  localparam int DIFF_W  = 32;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_RUN      = 3'd2,
    ST_APPLY    = 3'd3,
    ST_PASS_END = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/adjacent_swap_sweeper_if.sv
`default_nettype none
// ============================================================================
// adjacent_swap_sweeper_if: sweeper-to-checker window bus.
// Revision: 1.0
// ============================================================================
interface adjacent_swap_sweeper_if;
  import sweep_pkg::*;

  logic              chk_rst;
  coord_t            chk_x1, chk_y1, chk_x2, chk_y2;
  coord_t            chk_x3, chk_y3, chk_x4, chk_y4;
  logic              chk_res;
  logic              chk_complete;
  logic [DIFF_W-1:0] chk_difference;

  modport master (
    output chk_rst, chk_x1, chk_y1, chk_x2, chk_y2, chk_x3, chk_y3, chk_x4, chk_y4,
    input  chk_res, chk_complete, chk_difference
  );

  modport slave (
    input  chk_rst, chk_x1, chk_y1, chk_x2, chk_y2, chk_x3, chk_y3, chk_x4, chk_y4,
    output chk_res, chk_complete, chk_difference
  );

endinterface
`default_nettype wire

// File: rtl/adjacent_swap_sweeper_regfile.sv
`default_nettype none
// ============================================================================
// swap_tour_regfile: tour order storage with four window read ports, one
// random read port and a single-cycle exchange of two positions.
// Revision: 1.0
// ============================================================================
module swap_tour_regfile #(
  parameter int N  = 16,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] win_pos  [4],
  output logic [CW-1:0] win_city [4],
  input  logic [CW-1:0] rd_pos,
  output logic [CW-1:0] rd_city,
  input  logic          xchg_en,
  input  logic [CW-1:0] xchg_a,
  input  logic [CW-1:0] xchg_b
);

  logic [CW-1:0] tour_q [N];
  logic [CW-1:0] tour_d [N];

  always_comb begin
    for (int k = 0; k < N; k++) tour_d[k] = tour_q[k];
    if (xchg_en) begin
      tour_d[xchg_a] = tour_q[xchg_b];
      tour_d[xchg_b] = tour_q[xchg_a];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) tour_q[k] <= CW'(k);
    end else begin
      for (int k = 0; k < N; k++) tour_q[k] <= tour_d[k];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_win_rd
    assign win_city[g] = tour_q[win_pos[g]];
  end

  assign rd_city = tour_q[rd_pos];

endmodule
`default_nettype wire

// File: rtl/adjacent_swap_sweeper.sv
`default_nettype none
// ============================================================================
// adjacent_swap_sweeper: slides a 4-city window along the open tour, asks the
// checker about each window and exchanges the middle pair on improvement.
// Revision: 1.0
// ============================================================================
module adjacent_swap_sweeper
  import sweep_pkg::*;
#(
  parameter int  N          = 16,
  parameter int  MAX_PASSES = 8,
  localparam int CW         = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [CW-1:0]           load_idx,
  input  coord_t                  load_x,
  input  coord_t                  load_y,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             swaps,
  output logic [7:0]              passes,
  output logic [DIFF_W-1:0]       total_gain,
  input  logic [CW-1:0]           rd_idx,
  output logic [CW-1:0]           rd_city,
  adjacent_swap_sweeper_if.master chk
);

  state_e            state_q, state_d;
  logic [CW-1:0]     i_q, i_d;
  logic              pass_swapped_q, pass_swapped_d;
  logic [15:0]       swaps_q, swaps_d;
  logic [7:0]        passes_q, passes_d;
  logic [DIFF_W-1:0] gain_q, gain_d;
  logic              res_q, res_d;
  logic [DIFF_W-1:0] diff_q, diff_d;
  coord_t            chk_x_q [4], chk_x_d [4];
  coord_t            chk_y_q [4], chk_y_d [4];
  coord_t            cx_q [N], cx_d [N];
  coord_t            cy_q [N], cy_d [N];

  logic [CW-1:0]     win_pos  [4];
  logic [CW-1:0]     win_city [4];
  logic              xchg_en;
  logic              chk_rst_c;

  for (genvar g = 0; g < 4; g++) begin : g_win_pos
    assign win_pos[g] = i_q + CW'(g);
  end

  swap_tour_regfile #(.N(N), .CW(CW)) u_tour (
    .clk      (clk),
    .rst      (rst),
    .win_pos  (win_pos),
    .win_city (win_city),
    .rd_pos   (rd_idx),
    .rd_city  (rd_city),
    .xchg_en  (xchg_en),
    .xchg_a   (win_pos[1]),
    .xchg_b   (win_pos[2])
  );

  // Coordinates are writable only while idle; a load in the start cycle lands
  // before SETUP reads it.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cx_d[k] = cx_q[k];
      cy_d[k] = cy_q[k];
    end
    if (state_q == ST_IDLE && load_valid) begin
      cx_d[load_idx] = load_x;
      cy_d[load_idx] = load_y;
    end
  end

  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    pass_swapped_d = pass_swapped_q;
    swaps_d        = swaps_q;
    passes_d       = passes_q;
    gain_d         = gain_q;
    res_d          = res_q;
    diff_d         = diff_q;
    for (int k = 0; k < 4; k++) begin
      chk_x_d[k] = chk_x_q[k];
      chk_y_d[k] = chk_y_q[k];
    end
    xchg_en   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    chk_rst_c = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          swaps_d        = '0;
          passes_d       = '0;
          gain_d         = '0;
          i_d            = '0;
          pass_swapped_d = 1'b0;
          state_d        = ST_SETUP;
        end
      end
      ST_SETUP: begin
        for (int k = 0; k < 4; k++) begin
          chk_x_d[k] = cx_q[win_city[k]];
          chk_y_d[k] = cy_q[win_city[k]];
        end
        state_d = ST_RUN;
      end
      ST_RUN: begin
        chk_rst_c = 1'b0;
        if (chk.chk_complete) begin
          res_d   = chk.chk_res;
          diff_d  = chk.chk_difference;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (res_q) begin
          xchg_en        = 1'b1;
          pass_swapped_d = 1'b1;
          gain_d         = gain_q + diff_q;
          if (swaps_q != 16'hFFFF) swaps_d = swaps_q + 16'd1;
        end
        // i never exceeds N-4, so equality is the end-of-path test.
        if (i_q != CW'(N - 4)) begin
          i_d     = i_q + CW'(1);
          state_d = ST_SETUP;
        end else begin
          state_d = ST_PASS_END;
        end
      end
      ST_PASS_END: begin
        passes_d = passes_q + 8'd1;
        if (!pass_swapped_q || passes_d == 8'(MAX_PASSES)) begin
          state_d = ST_DONE;
        end else begin
          i_d            = '0;
          pass_swapped_d = 1'b0;
          state_d        = ST_SETUP;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      i_q            <= '0;
      pass_swapped_q <= 1'b0;
      swaps_q        <= '0;
      passes_q       <= '0;
      gain_q         <= '0;
      res_q          <= 1'b0;
      diff_q         <= '0;
      for (int k = 0; k < 4; k++) begin
        chk_x_q[k] <= '0;
        chk_y_q[k] <= '0;
      end
      for (int k = 0; k < N; k++) begin
        cx_q[k] <= '0;
        cy_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      i_q            <= i_d;
      pass_swapped_q <= pass_swapped_d;
      swaps_q        <= swaps_d;
      passes_q       <= passes_d;
      gain_q         <= gain_d;
      res_q          <= res_d;
      diff_q         <= diff_d;
      for (int k = 0; k < 4; k++) begin
        chk_x_q[k] <= chk_x_d[k];
        chk_y_q[k] <= chk_y_d[k];
      end
      for (int k = 0; k < N; k++) begin
        cx_q[k] <= cx_d[k];
        cy_q[k] <= cy_d[k];
      end
    end
  end

  assign swaps      = swaps_q;
  assign passes     = passes_q;
  assign total_gain = gain_q;

  assign chk.chk_rst = chk_rst_c;
  assign chk.chk_x1  = chk_x_q[0];
  assign chk.chk_y1  = chk_y_q[0];
  assign chk.chk_x2  = chk_x_q[1];
  assign chk.chk_y2  = chk_y_q[1];
  assign chk.chk_x3  = chk_x_q[2];
  assign chk.chk_y3  = chk_y_q[2];
  assign chk.chk_x4  = chk_x_q[3];
  assign chk.chk_y4  = chk_y_q[3];

endmodule
`default_nettype wire
